gray_rdptr_16_long: RTL and testbench

Read-side companion to the 16-state, 5-bit Gray write-pointer counter in the PCS elastic-buffer path. It tracks the Gray write pointer arriving from the write side (already two-flop synchronized), decodes it to binary, and keeps its own read pointer. It issues read addresses and returns its own Gray read pointer to the writer. It also polices the incoming pointer for illegal steps and enters a fault state until explicitly resynchronized.

---
 rtl/gray_rdptr_16_long_pkg.sv | 43 ++++
 rtl/gray_rdptr_16_long_if.sv | 27 ++
 rtl/gray_rdptr_16_long_step_chk.sv | 17 +
 rtl/gray_rdptr_16_long.sv | 84 ++++++++
 tb/tb_gray_rdptr_16_long.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/gray_rdptr_16_long_pkg.sv
// Shared Gray-code definitions for the 16-state, 5-bit PCS elastic-buffer pointers.
// The write-side counter and the read-side tracker both use these constants and
// conversions, so the two sides always agree on the code set.
package pcs_gray_pkg;

   localparam logic [4:0] G0  = 5'b00000;
   localparam logic [4:0] G1  = 5'b00001;
   localparam logic [4:0] G2  = 5'b00011;
   localparam logic [4:0] G3  = 5'b00010;
   localparam logic [4:0] G4  = 5'b00110;
   localparam logic [4:0] G5  = 5'b00111;
   localparam logic [4:0] G6  = 5'b00101;
   localparam logic [4:0] G7  = 5'b00100;
   localparam logic [4:0] G8  = 5'b01100;
   localparam logic [4:0] G9  = 5'b01101;
   localparam logic [4:0] G10 = 5'b01111;
   localparam logic [4:0] G11 = 5'b01110;
   localparam logic [4:0] G12 = 5'b01010;
   localparam logic [4:0] G13 = 5'b01011;
   localparam logic [4:0] G14 = 5'b01001;
   localparam logic [4:0] G15 = 5'b01000;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } rd_state_t;

   // Decode the low four Gray bits; bit4 carries no weight and is policed separately.
   function automatic logic [3:0] gray5_to_bin4(input logic [4:0] g);
      logic [3:0] b;
      b[3] = g[3];
      b[2] = b[3] ^ g[2];
      b[1] = b[2] ^ g[1];
      b[0] = b[1] ^ g[0];
      return b;
   endfunction

   // Encode a binary index into the 5-bit code set (bit4 always 0).
   function automatic logic [4:0] bin4_to_gray5(input logic [3:0] b);
      return {1'b0, b ^ (b >> 1)};
   endfunction

endpackage

// File: rtl/gray_rdptr_16_long_if.sv
// Bus between the synchronized write-pointer side / read consumer and the
// read-pointer tracker. The master drives pointer and requests, the slave
// (the tracker) returns read status and its own Gray pointer.
interface gray_rdptr_16_long_if #(
   parameter int ERR_CNT_W = 8
);
   logic [4:0]           wptr_gray;
   logic                 rd_req;
   logic                 resync;
   logic                 rd_ack;
   logic [3:0]           rd_addr;
   logic [4:0]           rptr_gray;
   logic [3:0]           level;
   logic                 empty;
   logic                 fault;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport master (
      output wptr_gray, rd_req, resync,
      input  rd_ack, rd_addr, rptr_gray, level, empty, fault, err_cnt
   );

   modport slave (
      input  wptr_gray, rd_req, resync,
      output rd_ack, rd_addr, rptr_gray, level, empty, fault, err_cnt
   );
endinterface

// File: rtl/gray_rdptr_16_long_step_chk.sv
// Combinational step policer: decodes the incoming Gray pointer and flags
// whether it is a legal hold or single forward step from the last sampled value.
module gray16_step_chk
   import pcs_gray_pkg::*;
(
   input  logic [4:0] wptr_gray,
   input  logic [3:0] wbin,
   output logic [3:0] d_in,
   output logic       legal
);
   logic [3:0] delta;

   assign d_in  = gray5_to_bin4(wptr_gray);
   // Mod-16 distance; 0 means the writer held, 1 means it advanced one code.
   assign delta = d_in - wbin;
   assign legal = !wptr_gray[4] && (delta <= 4'd1);
endmodule

// File: rtl/gray_rdptr_16_long.sv
// Read-side pointer tracker for the 16-entry PCS elastic buffer. Samples the
// synchronized Gray write pointer, keeps the binary read pointer and its Gray
// image for the writer, accepts reads, and latches a fault on illegal pointer
// steps until resync realigns the read pointer to the writer.
module gray_rdptr_16_long
   import pcs_gray_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   gray_rdptr_16_long_if.slave   bus
);
   logic [4:0]           wg_q;
   logic [3:0]           rbin;
   logic [4:0]           rptr_gray_q;
   logic                 rd_ack_q;
   rd_state_t            state;
   logic [ERR_CNT_W-1:0] err_cnt_q;

   logic [3:0]           wbin;
   logic [3:0]           d_in;
   logic                 legal;
   logic [3:0]           level;
   logic                 empty;
   logic                 in_run;
   logic                 rd_accept;
   logic [3:0]           rbin_inc;

   gray16_step_chk u_step_chk (
      .wptr_gray (bus.wptr_gray),
      .wbin      (wbin),
      .d_in      (d_in),
      .legal     (legal)
   );

   assign wbin     = gray5_to_bin4(wg_q);
   assign level    = wbin - rbin;
   assign in_run   = (state == ST_RUN);
   assign empty    = (level == 4'd0) || !in_run;
   assign rbin_inc = rbin + 4'd1;

   // A read is taken only in RUN, with data present, and not on a cycle that
   // either faults (illegal step) or realigns the pointer (resync).
   assign rd_accept = bus.rd_req && !empty && in_run && !bus.resync && legal;

   // Pointer tracking, read acceptance and the RUN/FAULT state machine.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wg_q        <= G0;
         rbin        <= 4'd0;
         rptr_gray_q <= G0;
         rd_ack_q    <= 1'b0;
         state       <= ST_RUN;
         err_cnt_q   <= '0;
      end else begin
         wg_q     <= bus.wptr_gray;
         rd_ack_q <= rd_accept;
         if (bus.resync) begin
            // Realign to the pointer sampled on this same edge; overrides a fault.
            rbin        <= d_in;
            rptr_gray_q <= bin4_to_gray5(d_in);
            state       <= ST_RUN;
         end else if (in_run) begin
            if (!legal) begin
               state <= ST_FAULT;
               if (err_cnt_q != '1)
                  err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end else if (rd_accept) begin
               rbin        <= rbin_inc;
               rptr_gray_q <= bin4_to_gray5(rbin_inc);
            end
         end
      end
   end

   assign bus.rd_ack    = rd_ack_q;
   assign bus.rd_addr   = rbin;
   assign bus.rptr_gray = rptr_gray_q;
   assign bus.level     = level;
   assign bus.empty     = empty;
   assign bus.fault     = !in_run;
   assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_gray_rdptr_16_long.sv
// Scoreboard bench for gray_rdptr_16_long: the driver pushes hand-computed
// expected outputs tagged with the cycle they apply to, a monitor pops and
// compares them one time unit after each rising edge.
module tb_gray_rdptr_16_long;
   logic clk;
   logic reset;

   gray_rdptr_16_long_if #(.ERR_CNT_W(8)) bus ();

   gray_rdptr_16_long #(.ERR_CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int          q_cyc[$];
   logic [23:0] q_exp[$];
   string       q_name[$];

   logic [4:0] gtab [16] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010,
                             5'b00110, 5'b00111, 5'b00101, 5'b00100,
                             5'b01100, 5'b01101, 5'b01111, 5'b01110,
                             5'b01010, 5'b01011, 5'b01001, 5'b01000};

   function automatic logic [23:0] ex(input logic ack, input logic [3:0] addr,
                                      input logic [4:0] rg, input logic [3:0] lvl,
                                      input logic emp, input logic flt,
                                      input logic [7:0] err);
      return {ack, addr, rg, lvl, emp, flt, err};
   endfunction

   function automatic logic [23:0] observed();
      return {bus.rd_ack, bus.rd_addr, bus.rptr_gray, bus.level,
              bus.empty, bus.fault, bus.err_cnt};
   endfunction

   task automatic compare(input string nm, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act ack=%0d addr=%0d rg=%b lvl=%0d emp=%0d flt=%0d err=%0d req ack=%0d addr=%0d rg=%b lvl=%0d emp=%0d flt=%0d err=%0d",
                  nm, act[23], act[22:19], act[18:14], act[13:10], act[9], act[8], act[7:0],
                  exp[23], exp[22:19], exp[18:14], exp[13:10], exp[9], exp[8], exp[7:0]);
      end else begin
         $display("ok   %s ack=%0d addr=%0d rg=%b lvl=%0d emp=%0d flt=%0d err=%0d",
                  nm, act[23], act[22:19], act[18:14], act[13:10], act[9], act[8], act[7:0]);
      end
   endtask

   // Monitor: compare every expectation that falls due on this edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            int          tc;
            logic [23:0] te;
            string       tn;
            tc = q_cyc.pop_front();
            te = q_exp.pop_front();
            tn = q_name.pop_front();
            if (tc < cyc) begin
               checks++;
               errors++;
               $display("FAIL %s stale expectation due %0d seen at %0d", tn, tc, cyc);
            end else begin
               compare(tn, observed(), te);
            end
         end
      end
   end

   // Drive one cycle of inputs at the falling edge; optionally queue the
   // outputs expected after the following rising edge.
   task automatic drive(input logic [4:0] w, input logic rq, input logic rs,
                        input logic rst_v, input logic chk,
                        input logic [23:0] e, input string nm);
      @(negedge clk);
      reset         = rst_v;
      bus.wptr_gray = w;
      bus.rd_req    = rq;
      bus.resync    = rs;
      if (chk) begin
         q_cyc.push_back(cyc + 1);
         q_exp.push_back(e);
         q_name.push_back(nm);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      bus.wptr_gray = 5'b00011;
      bus.rd_req    = 1'b0;
      bus.resync    = 1'b0;

      // Reset held: all outputs at reset values despite a nonzero pointer.
      drive(5'b00011, 0, 0, 1, 1, ex(0, 0, 5'b00000, 0, 1, 0, 0), "reset_hold");
      drive(5'b00011, 0, 0, 1, 1, ex(0, 0, 5'b00000, 0, 1, 0, 0), "reset_hold2");
      // Release: G0 -> G2 is a double step, so level=2 but the tracker faults.
      drive(5'b00011, 0, 0, 0, 1, ex(0, 0, 5'b00000, 2, 1, 1, 1), "reset_release");

      // Asynchronous reset clears the fault without a clock edge.
      @(negedge clk);
      reset = 1'b1;
      #1;
      compare("async_clear", observed(), ex(0, 0, 5'b00000, 0, 1, 0, 0));
      drive(5'b00000, 0, 0, 1, 0, '0, "");
      drive(5'b00000, 0, 0, 0, 1, ex(0, 0, 5'b00000, 0, 1, 0, 0), "idle_g0");

      // Fill.
      drive(5'b00001, 0, 0, 0, 1, ex(0, 0, 5'b00000, 1, 0, 0, 0), "fill1");
      drive(5'b00011, 0, 0, 0, 1, ex(0, 0, 5'b00000, 2, 0, 0, 0), "fill2");
      drive(5'b00010, 0, 0, 0, 1, ex(0, 0, 5'b00000, 3, 0, 0, 0), "fill3");

      // Drain: three acks, fourth request refused.
      drive(5'b00010, 1, 0, 0, 1, ex(1, 1, 5'b00001, 2, 0, 0, 0), "drain1");
      drive(5'b00010, 1, 0, 0, 1, ex(1, 2, 5'b00011, 1, 0, 0, 0), "drain2");
      drive(5'b00010, 1, 0, 0, 1, ex(1, 3, 5'b00010, 0, 1, 0, 0), "drain3");
      drive(5'b00010, 1, 0, 0, 1, ex(0, 3, 5'b00010, 0, 1, 0, 0), "drain4_empty");

      // Advance writer to G14 with no reads.
      for (int i = 4; i < 14; i++)
         drive(gtab[i], 0, 0, 0, 0, '0, "");
      drive(gtab[14], 0, 0, 0, 1, ex(0, 3, 5'b00010, 11, 0, 0, 0), "fill_to_g14");

      // Catch up to one behind the writer.
      for (int i = 0; i < 9; i++)
         drive(gtab[14], 1, 0, 0, 0, '0, "");
      drive(gtab[14], 1, 0, 0, 1, ex(1, 13, 5'b01011, 1, 0, 0, 0), "catch_up");

      // Wrap G14 -> G15 -> G0 while reading along.
      drive(5'b01000, 1, 0, 0, 1, ex(1, 14, 5'b01001, 1, 0, 0, 0), "wrap_g15");
      drive(5'b00000, 1, 0, 0, 1, ex(1, 15, 5'b01000, 1, 0, 0, 0), "wrap_g0");
      drive(5'b00000, 1, 0, 0, 1, ex(1, 0, 5'b00000, 0, 1, 0, 0), "wrap_rd0");

      // Fault on G2 -> G5 jump.
      drive(5'b00001, 0, 0, 0, 1, ex(0, 0, 5'b00000, 1, 0, 0, 0), "pre_g1");
      drive(5'b00011, 0, 0, 0, 1, ex(0, 0, 5'b00000, 2, 0, 0, 0), "pre_g2");
      drive(5'b00111, 1, 0, 0, 1, ex(0, 0, 5'b00000, 5, 1, 1, 1), "illegal_jump");
      drive(5'b00111, 1, 0, 0, 1, ex(0, 0, 5'b00000, 5, 1, 1, 1), "fault_ignores_read");
      drive(5'b00111, 0, 1, 0, 1, ex(0, 5, 5'b00111, 0, 1, 0, 1), "resync_exit");

      // Bit4 set with otherwise unchanged low bits is still illegal.
      drive(5'b10111, 0, 0, 0, 1, ex(0, 5, 5'b00111, 0, 1, 1, 2), "bit4_fault");
      drive(5'b00111, 0, 1, 0, 1, ex(0, 5, 5'b00111, 0, 1, 0, 2), "resync2");
      drive(5'b10111, 0, 1, 0, 1, ex(0, 5, 5'b00111, 0, 1, 0, 2), "resync_priority");
      drive(5'b00111, 0, 0, 0, 1, ex(0, 5, 5'b00111, 0, 1, 0, 2), "legal_hold");

      // Saturation: 300 rounds of resync followed by an illegal step.
      for (int k = 0; k < 300; k++) begin
         drive(5'b00111, 0, 1, 0, 0, '0, "");
         drive(5'b10111, 0, 0, 0, (k == 0 || k == 252 || k == 299),
               ex(0, 5, 5'b00111, 0, 1, 1, (k == 0) ? 8'd3 : 8'd255),
               (k == 0) ? "sat_first" : ((k == 252) ? "sat_reach" : "sat_hold"));
      end

      // Asynchronous reset in the middle of a read cycle.
      drive(5'b00111, 0, 1, 0, 1, ex(0, 5, 5'b00111, 0, 1, 0, 255), "resync3");
      drive(5'b00101, 0, 0, 0, 1, ex(0, 5, 5'b00111, 1, 0, 0, 255), "step_g6");
      @(negedge clk);
      bus.rd_req = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      compare("async_mid_read", observed(), ex(0, 0, 5'b00000, 0, 1, 0, 0));
      drive(5'b00000, 0, 0, 1, 0, '0, "");
      drive(5'b00000, 0, 0, 0, 1, ex(0, 0, 5'b00000, 0, 1, 0, 0), "post_reset");

      repeat (3) @(negedge clk);
      checks++;
      if (q_cyc.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending=%0d required=0", q_cyc.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
